// File: rtl/lsu_axil_master.sv
// lsu_axil_master: turns one core load/store into one AXI4-Lite transaction.
// Only one transaction is outstanding at a time. All AXI outputs come
// straight from registers.
// Optional feature macro: LSU_AXIL_TIMEOUT_EN adds a watchdog. When the
// watchdog expires, the transaction is abandoned and an error response is
// returned to the core.
module lsu_axil_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [31:0]           M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [31:0]           M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_READ, S_RDATA, S_RESP} state_e;

  state_e                state_q;
  logic                  req_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0]           rsp_rdata_q, wdata_q;
  logic [3:0]            wstrb_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                  busy, tmo;

  // Busy means an AXI transaction is in flight. This is the only time the
  // watchdog runs.
  assign busy = (state_q == S_WRITE) || (state_q == S_WRESP) ||
                (state_q == S_READ)  || (state_q == S_RDATA);

`ifdef LSU_AXIL_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES + 1 > 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q;

  // Watchdog: held at zero in IDLE, counts cycles spent waiting on AXI.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)  cnt_q <= '0;
    else if (busy) cnt_q <= cnt_q + 1'b1;
    else           cnt_q <= '0;
  end

  // Fires on the cycle the count reaches the limit, so VALID/READY drop next edge.
  assign tmo = busy && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  // Only bit 1 of a response code separates OKAY/EXOKAY from SLVERR/DECERR.
  logic unused_ok;
  assign unused_ok = ^{M_AXI_BRESP[0], M_AXI_RRESP[0], TIMEOUT_CYCLES[0]};

  // Main controller. Every output is registered. A timeout wins over a
  // handshake that arrives in the same cycle.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else if (tmo) begin
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_err_q   <= 1'b1;
      rsp_rdata_q <= '0;
      rsp_valid_q <= 1'b1;
      state_q     <= S_RESP;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            addr_q      <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            wdata_q     <= req_wdata;
            wstrb_q     <= req_wstrb;
            if (req_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WRITE;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= S_READ;
            end
          end
        end
        S_WRITE: begin
          if (awvalid_q && M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q && M_AXI_WREADY)   wvalid_q  <= 1'b0;
          if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
            bready_q <= 1'b1;
            state_q  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (M_AXI_BVALID) begin
            bready_q    <= 1'b0;
            rsp_err_q   <= M_AXI_BRESP[1];
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_READ: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (M_AXI_RVALID) begin
            rready_q    <= 1'b0;
            rsp_err_q   <= M_AXI_RRESP[1];
            rsp_rdata_q <= M_AXI_RDATA;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_lsu_axil_master.sv
// Directed bench for lsu_axil_master. The AXI slave is driven cycle by cycle
// from the stimulus. Expected values are hand constants.
module tb_lsu_axil_master;

  logic        ACLK = 1'b0, ARESETN = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0, rready;

  logic [31:0] mem [4];
  int n_chk = 0, n_fail = 0;

  lsu_axil_master #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic mem_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    for (int b = 0; b < 4; b++)
      if (strb[b]) mem[addr[3:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; req_wstrb = strb;
    step();
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
  endtask

  // Called on the first cycle rsp_valid should be high.
  task automatic finish_rsp(input logic [31:0] exp_data, input logic exp_err, input int hold);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, exp_data);
    chk("rsp_err", rsp_err, exp_err);
    chk("req_ready_busy", req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("rsp_valid_hold", rsp_valid, 1);
      chk("rsp_rdata_hold", rsp_rdata, exp_data);
      chk("rsp_err_hold", rsp_err, exp_err);
      chk("req_ready_hold", req_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] exp_addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [1:0] br);
    issue(1'b1, addr, data, strb);
    chk("awvalid_c1", awvalid, 1);
    chk("wvalid_c1", wvalid, 1);
    chk("awaddr", awaddr, exp_addr);
    chk("awprot", {29'd0, awprot}, 0);
    chk("wdata", wdata, data);
    chk("wstrb", {28'd0, wstrb}, {28'd0, strb});
    chk("bready_c1", bready, 0);
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    chk("awvalid_c2", awvalid, 0);
    chk("wvalid_c2", wvalid, 0);
    chk("bready_c2", bready, 1);
    mem_write(exp_addr, data, strb);
    bvalid = 1'b1; bresp = br;
    step();
    bvalid = 1'b0; bresp = 2'b00;
    chk("bready_c3", bready, 0);
    finish_rsp(32'h0, br[1], 0);
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] exp_addr, input logic [1:0] rr,
                      input int hold, input logic [31:0] exp_data, input logic exp_err);
    issue(1'b0, addr, 32'h0, 4'h0);
    chk("arvalid_c1", arvalid, 1);
    chk("araddr", araddr, exp_addr);
    chk("arprot", {29'd0, arprot}, 0);
    chk("awvalid_on_load", awvalid, 0);
    chk("rready_c1", rready, 0);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("arvalid_c2", arvalid, 0);
    chk("rready_c2", rready, 1);
    rvalid = 1'b1; rdata = mem[exp_addr[3:2]]; rresp = rr;
    step();
    rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    chk("rready_c3", rready, 0);
    finish_rsp(exp_data, exp_err, hold);
  endtask

  // One channel's READY comes first. The other arrives three cycles later.
  task automatic store_stagger(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic w_first);
    issue(1'b1, addr, data, strb);
    chk("stg_awvalid", awvalid, 1);
    chk("stg_wvalid", wvalid, 1);
    if (w_first) wready = 1'b1; else awready = 1'b1;
    step();
    wready = 1'b0; awready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (w_first) begin
        chk("stg_w_dropped", wvalid, 0);
        chk("stg_aw_held", awvalid, 1);
        chk("stg_awaddr", awaddr, addr);
      end else begin
        chk("stg_aw_dropped", awvalid, 0);
        chk("stg_w_held", wvalid, 1);
        chk("stg_wdata", wdata, data);
      end
      chk("stg_bready_lo", bready, 0);
      if (i == 2) begin
        if (w_first) awready = 1'b1; else wready = 1'b1;
      end
      step();
    end
    wready = 1'b0; awready = 1'b0;
    chk("stg_aw_done", awvalid, 0);
    chk("stg_w_done", wvalid, 0);
    chk("stg_bready_hi", bready, 1);
    mem_write(addr, data, strb);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    chk("stg_bready_drop", bready, 0);
    finish_rsp(32'h0, 1'b0, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;

    // Reset values while ARESETN is held low.
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_awaddr", awaddr, 0);
    step(); step();
    ARESETN = 1'b1;
    chk("rel_req_ready_pre", req_ready, 0);
    step();
    chk("rel_req_ready", req_ready, 1);

    // Stores 1..4, then read them back. Load 0xF is unaligned and maps to 0xC.
    store(32'h0, 32'h0, 32'h1, 4'hF, 2'b00);
    store(32'h4, 32'h4, 32'h2, 4'hF, 2'b00);
    store(32'h8, 32'h8, 32'h3, 4'hF, 2'b00);
    store(32'hE, 32'hC, 32'h4, 4'hF, 2'b00);
    load(32'h0, 32'h0, 2'b00, 0, 32'h1, 1'b0);
    load(32'h4, 32'h4, 2'b00, 0, 32'h2, 1'b0);
    load(32'h8, 32'h8, 2'b00, 0, 32'h3, 1'b0);
    load(32'hF, 32'hC, 2'b00, 0, 32'h4, 1'b0);

    // A zero strobe still issues a write. DECERR is reported as an error.
    store(32'h8, 32'h8, 32'hFFFF_FFFF, 4'h0, 2'b00);
    store(32'hC, 32'hC, 32'h5, 4'hF, 2'b11);

    // SLVERR load with the response back-pressured.
    load(32'h8, 32'h8, 2'b10, 5, 32'h3, 1'b1);

    // Staggered AW/W completion in both orders, with a partial strobe.
    store_stagger(32'h0, 32'hA5A5_5A5A, 4'hF, 1'b1);
    store_stagger(32'h4, 32'h0000_0077, 4'h1, 1'b0);
    load(32'h0, 32'h0, 2'b00, 0, 32'hA5A5_5A5A, 1'b0);
    load(32'h4, 32'h4, 2'b00, 0, 32'h0000_0077, 1'b0);

    // Reset asserted while waiting for B abandons the write.
    issue(1'b1, 32'h8, 32'h9, 4'hF);
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    chk("mid_bready", bready, 1);
    #2 ARESETN = 1'b0;
    #1;
    chk("arst_bready", bready, 0);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_awaddr", awaddr, 0);
    chk("arst_wdata", wdata, 0);
    chk("arst_wstrb", {28'd0, wstrb}, 0);
    step();
    ARESETN = 1'b1;
    step();
    chk("arst_rel_req_ready", req_ready, 1);
    chk("arst_rel_rsp_valid", rsp_valid, 0);
    step();
    chk("arst_rel_rsp_valid2", rsp_valid, 0);
    load(32'h8, 32'h8, 2'b00, 0, 32'h3, 1'b0);

`ifdef LSU_AXIL_TIMEOUT_EN
    // AWREADY never arrives: AWVALID is high for exactly 16 cycles.
    issue(1'b1, 32'h0, 32'h1, 4'hF);
    chk("tmo_awvalid_c1", awvalid, 1);
    wready = 1'b1;
    step();
    wready = 1'b0;
    chk("tmo_wvalid_done", wvalid, 0);
    for (int c = 2; c <= 16; c++) begin
      chk("tmo_awvalid_held", awvalid, 1);
      step();
    end
    chk("tmo_awvalid_drop", awvalid, 0);
    finish_rsp(32'h0, 1'b1, 0);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_axil_master.md
LSU_AXIL_MASTER -- requirements
Module: lsu_axil_master

Interface
REQ-001 ADDR_WIDTH, 32, byte-address width of core request and AXI address.
REQ-002 TIMEOUT_CYCLES, 255, watchdog limit in ACLK cycles; used only with LSU_AXIL_TIMEOUT_EN.
REQ-003 ACLK  in  1  clock; all state updates on rising edge.
REQ-004 ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 req_valid in 1 / req_ready out 1: core request handshake.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_addr in ADDR_WIDTH, req_wdata in 32, req_wstrb in 4: request payload.
REQ-008 rsp_valid out 1 / rsp_ready in 1: response handshake; rsp_rdata out 32 (load data); rsp_err out 1 (SLVERR/DECERR/timeout).
REQ-009 M_AXI_AWADDR out ADDR_WIDTH, M_AXI_AWPROT out 3, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1.
REQ-010 M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1, M_AXI_WREADY in 1.
REQ-011 M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1.
REQ-012 M_AXI_ARADDR out ADDR_WIDTH, M_AXI_ARPROT out 3, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1.
REQ-013 M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1.

Function
REQ-014 Upstream stage of the AXI4-Lite data memory; converts one core load/store into one AXI4-Lite transaction; at most one outstanding.
REQ-015 FSM states IDLE, WRITE, WRESP, READ, RDATA, RESP; req_ready = 1 only in IDLE.
REQ-016 On req_valid & req_ready: capture payload into registers; all AXI outputs driven from registers only, never combinationally from core inputs.
REQ-017 AXI addresses = {req_addr[ADDR_WIDTH-1:2], 2'b00}; AWPROT = ARPROT = 3'b000; WSTRB = captured req_wstrb (0 still issues a write).
REQ-018 IDLE -> WRITE (store): AWVALID and WVALID both high the next cycle.
REQ-019 WRITE: each VALID held until its READY is sampled high, then dropped next cycle; AW and W complete independently, in any order or same cycle; both done -> WRESP with BREADY = 1.
REQ-020 WRESP: on BVALID: rsp_err = BRESP[1], rsp_rdata = 0, BREADY low, -> RESP.
REQ-021 IDLE -> READ (load): ARVALID held until ARREADY; -> RDATA with RREADY = 1.
REQ-022 RDATA: on RVALID: capture RDATA into rsp_rdata, rsp_err = RRESP[1], RREADY low, -> RESP.
REQ-023 RESP: rsp_valid = 1 with stable rsp_rdata/rsp_err until rsp_ready sampled high; then -> IDLE.
REQ-024 Any VALID, once asserted, is never dropped before its READY; BREADY/RREADY high only in WRESP/RDATA.
REQ-025 Latency (slave always ready, B/R one cycle after handshake): request accepted cycle 0, AW/W or AR cycle 1, B/R cycle 2, rsp_valid cycle 3.

Reset
REQ-026 While ARESETN low: state IDLE; req_ready, rsp_valid, rsp_err, all AXI VALID/READY outputs 0; rsp_rdata, addresses, WDATA, WSTRB 0.
REQ-027 req_ready = 1 from the first rising edge after ARESETN deasserts.
REQ-028 Reset mid-transaction abandons it immediately; no response is produced.

Configuration
REQ-029 LSU_AXIL_TIMEOUT_EN defined: 8-bit-minimum counter cleared on leaving IDLE and incremented each cycle outside IDLE/RESP; on reaching TIMEOUT_CYCLES all AXI VALID/READY drop next cycle, -> RESP with rsp_err = 1, rsp_rdata = 0.
REQ-030 LSU_AXIL_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely for AXI handshakes.

Verification
REQ-031 Store addr 0x4, data 0x00000002, strb 0xF, zero-wait slave, BRESP OKAY -> one AW/W beat at 0x4, rsp_valid cycle 3, rsp_err 0.
REQ-032 Stores 1..4 to 0x0/0x4/0x8/0xC, then loads from same addresses -> rsp_rdata 0x1, 0x2, 0x3, 0x4.
REQ-033 WREADY 3 cycles before AWREADY, then reversed -> WVALID/AWVALID each drop exactly after own handshake; single B accepted.
REQ-034 Load with RRESP SLVERR, rsp_ready held low 5 cycles -> rsp_valid, rsp_err = 1, rsp_rdata stable 5 cycles; req_ready 0 throughout.
REQ-035 ARESETN low during WRESP -> all outputs 0 asynchronously; req_ready 1 after release; no rsp_valid.
REQ-036 With LSU_AXIL_TIMEOUT_EN, TIMEOUT_CYCLES = 16, AWREADY never asserted -> AWVALID drops after 16 cycles, rsp_err = 1.
